// File: rtl/packet_tx_arbiter.sv
// Multi-channel packet serialiser: arbitrates between request FIFOs and emits
// header, MSB-first payload and an optional XOR checksum onto a byte-wide UART link.
module packet_tx_arbiter #(
    parameter int NUM_CH    = 3,
    parameter int MAX_BYTES = 38,
    parameter int LEN_W     = 6,
    parameter int RR_MODE   = 0,
    parameter int CHECKSUM  = 0
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          tx_busy,
    output logic                          tx_en,
    output logic [7:0]                    tx_data,
    input  logic [NUM_CH-1:0]             ch_valid,
    output logic [NUM_CH-1:0]             ch_re,
    input  logic [NUM_CH*8-1:0]           ch_type,
    input  logic [NUM_CH*LEN_W-1:0]       ch_len,
    input  logic [NUM_CH*MAX_BYTES*8-1:0] ch_data,
    output logic                          busy,
    output logic                          pkt_done,
    output logic [2:0]                    active_ch
);

    localparam int SH_W = MAX_BYTES * 8;
    localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_BYTES);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_HEADER  = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CHECK   = 2'd3
    } state_t;

    state_t            state_r, state_nxt_s;
    logic              tx_en_r, tx_en_nxt_s;
    logic [7:0]        tx_data_r, tx_data_nxt_s;
    logic [NUM_CH-1:0] ch_re_r, ch_re_nxt_s;
    logic              busy_r, pkt_done_r, pkt_done_nxt_s;
    logic [2:0]        active_r, active_nxt_s;
    logic [2:0]        rr_ptr_r, rr_ptr_nxt_s;
    logic [7:0]        type_r, type_nxt_s;
    logic [LEN_W-1:0]  cnt_r, cnt_nxt_s;
    logic [SH_W-1:0]   shift_r, shift_nxt_s;
    logic [7:0]        acc_r, acc_nxt_s;

    logic [7:0]        valid_pad_s;
    logic [2:0]        start_s;
    logic [3:0]        cand_s;
    logic              win_valid_s;
    logic [2:0]        win_idx_s;
    logic [7:0]        sel_type_s;
    logic [LEN_W-1:0]  sel_len_s;
    logic [LEN_W-1:0]  clamp_len_s;
    logic [SH_W-1:0]   sel_data_s;
    logic [NUM_CH-1:0] grant_vec_s;
    logic              link_free_s;
    logic              issue_s;

    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    assign link_free_s = !(tx_en_r | tx_busy);
    // The cycle in which the FIFO is popped is never used to issue, giving the header a one-cycle gap.
    assign issue_s     = link_free_s && !(|ch_re_r);
    assign clamp_len_s = (sel_len_s > MAX_LEN) ? MAX_LEN : sel_len_s;

    // Winner search: rotating start for round-robin, channel 0 for fixed priority.
    always_comb begin
        valid_pad_s = 8'(ch_valid);
        start_s     = (RR_MODE != 0) ? rr_ptr_r : 3'd0;
        win_valid_s = 1'b0;
        win_idx_s   = 3'd0;
        cand_s      = 4'd0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand_s = {1'b0, start_s} + 4'(k);
            if (cand_s >= 4'(NUM_CH)) begin
                cand_s = cand_s - 4'(NUM_CH);
            end else begin
                cand_s = cand_s;
            end
            if (!win_valid_s && valid_pad_s[cand_s[2:0]]) begin
                win_valid_s = 1'b1;
                win_idx_s   = cand_s[2:0];
            end else begin
                win_valid_s = win_valid_s;
            end
        end
    end

    // Multiplex the winning channel's fields and build its read-enable vector.
    always_comb begin
        sel_type_s  = 8'd0;
        sel_len_s   = '0;
        sel_data_s  = '0;
        grant_vec_s = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (3'(i) == win_idx_s) begin
                sel_type_s     = ch_type[i*8 +: 8];
                sel_len_s      = ch_len[i*LEN_W +: LEN_W];
                sel_data_s     = ch_data[i*SH_W +: SH_W];
                grant_vec_s[i] = 1'b1;
            end else begin
                grant_vec_s[i] = 1'b0;
            end
        end
    end

    // Next-state and next-output logic for the packet FSM.
    always_comb begin
        state_nxt_s    = state_r;
        tx_en_nxt_s    = 1'b0;
        tx_data_nxt_s  = tx_data_r;
        ch_re_nxt_s    = '0;
        pkt_done_nxt_s = 1'b0;
        active_nxt_s   = active_r;
        rr_ptr_nxt_s   = rr_ptr_r;
        type_nxt_s     = type_r;
        cnt_nxt_s      = cnt_r;
        shift_nxt_s    = shift_r;
        acc_nxt_s      = acc_r;
        case (state_r)
            S_IDLE: begin
                if (link_free_s && win_valid_s) begin
                    state_nxt_s  = S_HEADER;
                    type_nxt_s   = sel_type_s;
                    cnt_nxt_s    = clamp_len_s;
                    shift_nxt_s  = sel_data_s;
                    ch_re_nxt_s  = grant_vec_s;
                    active_nxt_s = win_idx_s;
                    rr_ptr_nxt_s = (win_idx_s == 3'(NUM_CH - 1)) ? 3'd0 : win_idx_s + 3'd1;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_HEADER: begin
                if (issue_s) begin
                    tx_en_nxt_s   = 1'b1;
                    tx_data_nxt_s = type_r;
                    acc_nxt_s     = type_r;
                    if (cnt_r != '0) begin
                        state_nxt_s = S_PAYLOAD;
                    end else if (CHECKSUM != 0) begin
                        state_nxt_s = S_CHECK;
                    end else begin
                        state_nxt_s    = S_IDLE;
                        pkt_done_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = S_HEADER;
                end
            end
            S_PAYLOAD: begin
                if (issue_s) begin
                    tx_en_nxt_s   = 1'b1;
                    tx_data_nxt_s = shift_r[SH_W-1 -: 8];
                    shift_nxt_s   = shift_r << 8;
                    acc_nxt_s     = csum_update(acc_r, shift_r[SH_W-1 -: 8]);
                    cnt_nxt_s     = cnt_r - LEN_W'(1);
                    if (cnt_r != LEN_W'(1)) begin
                        state_nxt_s = S_PAYLOAD;
                    end else if (CHECKSUM != 0) begin
                        state_nxt_s = S_CHECK;
                    end else begin
                        state_nxt_s    = S_IDLE;
                        pkt_done_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = S_PAYLOAD;
                end
            end
            S_CHECK: begin
                if (issue_s) begin
                    tx_en_nxt_s    = 1'b1;
                    tx_data_nxt_s  = acc_r;
                    pkt_done_nxt_s = 1'b1;
                    state_nxt_s    = S_IDLE;
                end else begin
                    state_nxt_s = S_CHECK;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any packet in flight.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_r    <= S_IDLE;
            tx_en_r    <= 1'b0;
            tx_data_r  <= 8'd0;
            ch_re_r    <= '0;
            busy_r     <= 1'b0;
            pkt_done_r <= 1'b0;
            active_r   <= 3'd0;
            rr_ptr_r   <= 3'd0;
            type_r     <= 8'd0;
            cnt_r      <= '0;
            shift_r    <= '0;
            acc_r      <= 8'd0;
        end else begin
            state_r    <= state_nxt_s;
            tx_en_r    <= tx_en_nxt_s;
            tx_data_r  <= tx_data_nxt_s;
            ch_re_r    <= ch_re_nxt_s;
            busy_r     <= (state_nxt_s != S_IDLE);
            pkt_done_r <= pkt_done_nxt_s;
            active_r   <= active_nxt_s;
            rr_ptr_r   <= rr_ptr_nxt_s;
            type_r     <= type_nxt_s;
            cnt_r      <= cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            acc_r      <= acc_nxt_s;
        end
    end

    assign tx_en     = tx_en_r;
    assign tx_data   = tx_data_r;
    assign ch_re     = ch_re_r;
    assign busy      = busy_r;
    assign pkt_done  = pkt_done_r;
    assign active_ch = active_r;

endmodule

// File: tb/tb_packet_tx_arbiter.sv
// Randomised bench for packet_tx_arbiter: a fixed-priority/no-checksum instance and a
// round-robin/checksum instance, each checked every cycle against a packet-level model.
module tb_packet_tx_arbiter;

    localparam int NCH = 3;
    localparam int MB  = 38;
    localparam int LW  = 6;
    localparam int PW  = MB * 8;
    localparam int DW  = NCH * PW;

    typedef struct packed {
        logic [7:0]    typ;
        logic [LW-1:0] len;
        logic [PW-1:0] data;
    } pkt_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              resetn;
    logic              tx_busy;
    logic              tx_en     [2];
    logic [7:0]        tx_data   [2];
    logic [NCH-1:0]    ch_valid  [2];
    logic [NCH-1:0]    ch_re     [2];
    logic [NCH*8-1:0]  ch_type   [2];
    logic [NCH*LW-1:0] ch_len    [2];
    logic [DW-1:0]     ch_data   [2];
    logic              busy      [2];
    logic              pkt_done  [2];
    logic [2:0]        active_ch [2];

    packet_tx_arbiter #(.NUM_CH(NCH), .MAX_BYTES(MB), .LEN_W(LW), .RR_MODE(0), .CHECKSUM(0)) u_fixed (
        .clk(clk), .resetn(resetn), .tx_busy(tx_busy),
        .tx_en(tx_en[0]), .tx_data(tx_data[0]),
        .ch_valid(ch_valid[0]), .ch_re(ch_re[0]), .ch_type(ch_type[0]),
        .ch_len(ch_len[0]), .ch_data(ch_data[0]),
        .busy(busy[0]), .pkt_done(pkt_done[0]), .active_ch(active_ch[0])
    );

    packet_tx_arbiter #(.NUM_CH(NCH), .MAX_BYTES(MB), .LEN_W(LW), .RR_MODE(1), .CHECKSUM(1)) u_rr (
        .clk(clk), .resetn(resetn), .tx_busy(tx_busy),
        .tx_en(tx_en[1]), .tx_data(tx_data[1]),
        .ch_valid(ch_valid[1]), .ch_re(ch_re[1]), .ch_type(ch_type[1]),
        .ch_len(ch_len[1]), .ch_data(ch_data[1]),
        .busy(busy[1]), .pkt_done(pkt_done[1]), .active_ch(active_ch[1])
    );

    // Reference model: per-channel request FIFOs and the byte stream still owed per instance.
    pkt_t       chq [2][NCH][$];
    logic [7:0] exp_q [2][$];
    int         rr_next [2];
    logic       prev_tx [2];
    logic       prev_re [2];
    logic [7:0] last_data [2];
    logic [2:0] last_ch [2];
    int         sent_in_pkt [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic pkt_t make_pkt(input logic [7:0] t, input logic [LW-1:0] l);
        pkt_t p;
        p.typ = t;
        p.len = l;
        for (int i = 0; i < MB; i++) p.data[i*8 +: 8] = 8'($urandom);
        return p;
    endfunction

    function automatic bit any_pending(input int d);
        for (int c = 0; c < NCH; c++) if (chq[d][c].size() > 0) return 1'b1;
        return 1'b0;
    endfunction

    // Instance 0 is fixed priority, instance 1 round-robin from the pointer.
    function automatic int pick_winner(input int d);
        int start;
        start = (d == 1) ? rr_next[d] : 0;
        for (int k = 0; k < NCH; k++) begin
            if (chq[d][(start + k) % NCH].size() > 0) return (start + k) % NCH;
        end
        return 0;
    endfunction

    task automatic push_bytes(input int d, input pkt_t p);
        int n;
        logic [7:0] acc, b;
        n = (p.len > MB) ? MB : int'(p.len);
        exp_q[d].push_back(p.typ);
        acc = p.typ;
        for (int i = 0; i < n; i++) begin
            b = p.data[PW-1-8*i -: 8];
            exp_q[d].push_back(b);
            acc = acc ^ b;
        end
        if (d == 1) exp_q[d].push_back(acc);
    endtask

    task automatic drive_inputs();
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                if (chq[d][c].size() > 0) begin
                    ch_valid[d][c]          = 1'b1;
                    ch_type[d][c*8 +: 8]    = chq[d][c][0].typ;
                    ch_len[d][c*LW +: LW]   = chq[d][c][0].len;
                    ch_data[d][c*PW +: PW]  = chq[d][c][0].data;
                end else begin
                    ch_valid[d][c]          = 1'b0;
                    ch_type[d][c*8 +: 8]    = 8'($urandom);
                end
            end
        end
    endtask

    // One clock: advance the model from the inputs present at the edge, then compare.
    task automatic step();
        logic           e_tx, e_done, ev_ok;
        logic [NCH-1:0] e_re;
        int             w;
        pkt_t           p;
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            e_tx = 1'b0; e_done = 1'b0; e_re = '0;
            if (!resetn) begin
                exp_q[d].delete();
                rr_next[d] = 0; last_data[d] = 8'd0; last_ch[d] = 3'd0; sent_in_pkt[d] = 0;
            end else begin
                ev_ok = !tx_busy && !prev_tx[d] && !prev_re[d];
                if (ev_ok && exp_q[d].size() > 0) begin
                    e_tx = 1'b1;
                    last_data[d] = exp_q[d].pop_front();
                    sent_in_pkt[d]++;
                    e_done = (exp_q[d].size() == 0);
                end else if (ev_ok && any_pending(d)) begin
                    w = pick_winner(d);
                    e_re[w] = 1'b1;
                    last_ch[d] = 3'(w);
                    rr_next[d] = (w + 1) % NCH;
                    p = chq[d][w].pop_front();
                    push_bytes(d, p);
                    sent_in_pkt[d] = 0;
                end
            end
            prev_tx[d] = e_tx;
            prev_re[d] = |e_re;
            check_eq($sformatf("d%0d tx_en", d),     32'(tx_en[d]),     32'(e_tx));
            check_eq($sformatf("d%0d ch_re", d),     32'(ch_re[d]),     32'(e_re));
            check_eq($sformatf("d%0d pkt_done", d),  32'(pkt_done[d]),  32'(e_done));
            check_eq($sformatf("d%0d busy", d),      32'(busy[d]),      32'(exp_q[d].size() > 0));
            check_eq($sformatf("d%0d active_ch", d), 32'(active_ch[d]), 32'(last_ch[d]));
            check_eq($sformatf("d%0d tx_data", d),   32'(tx_data[d]),   32'(last_data[d]));
        end
    endtask

    task automatic run(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            drive_inputs();
        end
    endtask

    initial begin
        pkt_t p;
        int   burst, rst_hold, guard;
        bit   rst_done, drained;
        resetn = 1'b0;
        tx_busy = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ch_valid[d] = '0; ch_type[d] = '0; ch_len[d] = '0; ch_data[d] = '0;
            rr_next[d] = 0; prev_tx[d] = 1'b0; prev_re[d] = 1'b0;
            last_data[d] = 8'd0; last_ch[d] = 3'd0; sent_in_pkt[d] = 0;
        end
        drive_inputs();
        run(3);
        resetn = 1'b1;

        // Directed: 0x02/ABCD on channel 1, and checksum packet 0x03/10 20 40 (trailer 0x73).
        p = make_pkt(8'h02, 6'd2);
        p.data[PW-1 -: 16] = 16'hABCD;
        chq[0][1].push_back(p);
        p = make_pkt(8'h03, 6'd3);
        p.data[PW-1 -: 24] = 24'h102040;
        chq[1][0].push_back(p);
        drive_inputs();
        run(30);

        // Length clamp (50 -> 38) and header-only packets.
        for (int d = 0; d < 2; d++) begin
            chq[d][2].push_back(make_pkt(8'h55, 6'd50));
            chq[d][0].push_back(make_pkt(8'h11, 6'd0));
        end
        drive_inputs();
        run(200);

        // Random traffic with all channels backlogged, busy bursts and one mid-packet reset.
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < NCH; c++)
                for (int k = 0; k < 6; k++)
                    chq[d][c].push_back(make_pkt(8'($urandom), 6'($urandom_range(0, 63))));
        drive_inputs();
        burst = 0; rst_hold = 0; rst_done = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            step();
            if (burst > 0) begin
                tx_busy = 1'b1; burst--;
            end else if (i == 60 || $urandom_range(0, 39) == 0) begin
                tx_busy = 1'b1; burst = 9;
            end else begin
                tx_busy = ($urandom_range(0, 3) == 0);
            end
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) resetn = 1'b1;
            end else if (!rst_done && sent_in_pkt[0] == 5 && exp_q[0].size() > 0) begin
                resetn = 1'b0; rst_hold = 2; rst_done = 1'b1;
            end
            drive_inputs();
        end

        resetn = 1'b1;
        tx_busy = 1'b0;
        guard = 0;
        while ((any_pending(0) || any_pending(1) || exp_q[0].size() > 0 || exp_q[1].size() > 0)
               && guard < 20000) begin
            step();
            drive_inputs();
            guard++;
        end
        drained = !(any_pending(0) || any_pending(1) || exp_q[0].size() > 0 || exp_q[1].size() > 0);
        check_eq("drain", 32'(drained), 32'd1);
        run(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/packet_tx_arbiter.md
# packet_tx_arbiter

Parametrised successor to the DMA packet sender: serialises fixed-format packets from `NUM_CH` request channels onto a one-byte UART-style transmit link. Each channel supplies a type byte, a variable payload length and a payload word; the block arbitrates (fixed priority or round-robin), emits header, payload MSB-first and an optional XOR checksum byte. It sits between the DMA request queues (FWFT FIFOs) and the UART transmitter.

## Interface
- `NUM_CH`, 3: number of request channels (1..8).
- `MAX_BYTES`, 38: maximum payload bytes per packet.
- `LEN_W`, 6: width of per-channel length field; must satisfy 2^LEN_W > MAX_BYTES.
- `RR_MODE`, 0: 0 = fixed priority (lowest index wins), 1 = round-robin.
- `CHECKSUM`, 0: 1 = append one XOR checksum byte after the payload.

- `clk` input 1: sole clock.
- `resetn` input 1: synchronous, active-low reset.
- `tx_busy` input 1: UART transmitter busy.
- `tx_en` output 1: one-cycle pulse; `tx_data` is valid.
- `tx_data` output 8: byte to transmit.
- `ch_valid` input NUM_CH: channel i has a packet at its FIFO head.
- `ch_re` output NUM_CH: one-cycle read-enable pulse, at most one bit set.
- `ch_type` input NUM_CH*8: header byte of channel i at bits [8i+7:8i].
- `ch_len` input NUM_CH*LEN_W: payload byte count of channel i.
- `ch_data` input NUM_CH*MAX_BYTES*8: payload of channel i; byte 0 is the most-significant byte of the slice.
- `busy` output 1: high whenever state is not IDLE.
- `pkt_done` output 1: one-cycle pulse in the cycle the last byte of a packet is issued.
- `active_ch` output 3: index of the channel being serviced; holds last value in IDLE.

## Operation
- Internal `link_free = !(tx_en | tx_busy)`; a byte is issued only when `link_free` is high, so consecutive bytes are at least 2 cycles apart.
- States: IDLE, HEADER, PAYLOAD, CHECK.
- IDLE: if `link_free` and any `ch_valid`, select winner; in the same edge latch its `ch_type`, `ch_len` (clamped to MAX_BYTES), `ch_data` into shift register, pulse its `ch_re`, set `active_ch`, go HEADER. Data on `ch_*` must be valid while `ch_valid` is high (FWFT).
- Fixed priority: lowest set index of `ch_valid`.
- Round-robin: search starts at (last granted + 1) mod NUM_CH; pointer resets to 0 (search starts at channel 0); updated on each grant.
- HEADER: on `link_free`, issue type byte, checksum accumulator ← type byte; go PAYLOAD if len>0, else CHECK if CHECKSUM, else IDLE.
- PAYLOAD: on `link_free`, issue top byte of shift register, shift left 8, XOR into accumulator, decrement remaining count; after last byte go CHECK (CHECKSUM=1) or IDLE.
- CHECK: on `link_free`, issue accumulator, go IDLE.
- `pkt_done` pulses with the `tx_en` of the final byte (header, last payload or checksum).
- `ch_valid` changes after grant are ignored until return to IDLE.

## Timing
- Reset (resetn=0 at clk edge): state IDLE, `tx_en`=0, `tx_data`=0, `ch_re`=0, `busy`=0, `pkt_done`=0, `active_ch`=0, RR pointer cleared. Reset mid-packet aborts immediately; no further bytes; partial packet is not resumed.
- Grant cycle: `ch_re` registered, high one cycle after the IDLE decision edge; header `tx_en` no earlier than 2 cycles after the grant edge.
- With `tx_busy` held low: packet of L payload bytes occupies 2·(1+L+CHECKSUM) cycles from first `tx_en` to IDLE-ready.
- `tx_en` is a single-cycle pulse; `tx_data` holds its value until the next issued byte.
- Back-to-back packets: new grant allowed in first IDLE cycle with `link_free`.
- len=0 with CHECKSUM=0: header-only packet, `pkt_done` on header byte.

## Test plan
- Single channel 1, type 0x02, len 2, data 0xABCD…, tx_busy low -> bytes 0x02,0xAB,0xCD; `ch_re`[1] one pulse; `pkt_done` on 0xCD.
- RR_MODE=0, all three valid continuously -> channel 0 always granted; RR_MODE=1 same stimulus -> grant order 0,1,2,0,1,2.
- CHECKSUM=1, type 0x03, len 3 bytes 0x10,0x20,0x40 -> trailing byte 0x73.
- tx_busy held high 10 cycles mid-payload -> no `tx_en` during busy; byte order unchanged after release.
- ch_len = 50 with MAX_BYTES=38 -> exactly 38 payload bytes sent; len=0 -> header only.
- resetn low during payload byte 5 -> `tx_en`, `busy` low next cycle; next packet starts cleanly with header.
